mux_scan_tdm: RTL and testbench

Parametrised N-channel, W-bit time-division multiplexer. It scans the enabled input channels in round-robin order and registers one channel's data onto a single output lane. Each beat is presented with a valid/ready handshake, and a programmable dwell gap can be inserted between beats. It is the sequential successor to the combinational 8:1 mux: the select is generated internally, and a channel mask, backpressure and frame marking are added.

---
 rtl/mux_scan_tdm.sv | 97 +++++++++
 tb/tb_mux_scan_tdm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_tdm.sv
// mux_scan_tdm: round-robin TDM scan of the masked input channels onto one
// registered valid/ready lane, with an optional idle gap between beats.
module mux_scan_tdm #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 8,
    parameter int SEL_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N-1:0]       mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N*W-1:0]     I,
    output logic [W-1:0]       y,
    output logic [SEL_W-1:0]   sel,
    output logic               y_valid,
    input  logic               y_ready,
    output logic               frame_start
);
    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
    state_t state, state_n;
    logic [DWELL_W-1:0] cnt;
    logic [SEL_W-1:0] base, lo, hi, nxt;
    logic found, cap, drop, load;

    // From IDLE the search starts past the top index so the lowest enabled wins
    always_comb begin
        base  = (state == IDLE) ? SEL_W'(N-1) : sel;
        lo    = '0;
        hi    = '0;
        found = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (mask[i]) lo = SEL_W'(i);
            if (mask[i] && i > int'(base)) begin
                hi    = SEL_W'(i);
                found = 1'b1;
            end
        end
        nxt = found ? hi : lo;
    end

    always_comb begin
        state_n = state;
        cap     = 1'b0;
        drop    = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: if (en && |mask) begin
                cap     = 1'b1;
                state_n = PRESENT;
            end
            PRESENT: if (y_ready) begin
                if (!en || !(|mask)) begin
                    drop    = 1'b1;
                    state_n = IDLE;
                end else if (dwell == '0) begin
                    cap = 1'b1;
                end else begin
                    drop    = 1'b1;
                    load    = 1'b1;
                    state_n = GAP;
                end
            end
            GAP: if (!en) begin
                state_n = IDLE;
            end else if (cnt == DWELL_W'(1)) begin
                cap     = |mask;
                state_n = |mask ? PRESENT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            y           <= '0;
            sel         <= '0;
            y_valid     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= load ? dwell : (state == GAP && cnt != '0) ? cnt - 1'b1 : cnt;
            if (cap) begin
                sel         <= nxt;
                y           <= I[int'(nxt)*W +: W];
                y_valid     <= 1'b1;
                frame_start <= (state == IDLE) || (nxt <= sel);
            end else if (drop) begin
                y_valid     <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_tdm.sv
// tb_mux_scan_tdm: table vectors, directed corner sequences and a randomized
// run against a channel-search reference model.
module tb_mux_scan_tdm;
    localparam int N = 8;
    localparam int W = 1;
    localparam int SEL_W = 3;

    logic clk = 0, rst_n = 0, en = 0, y_ready = 0;
    logic [N-1:0] mask = '0;
    logic [7:0] dwell = '0;
    logic [N*W-1:0] I = '0;
    logic [W-1:0] y;
    logic [SEL_W-1:0] sel;
    logic y_valid, frame_start;
    int n_chk = 0, n_fail = 0;

    mux_scan_tdm #(.N(N), .W(W), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mask(mask), .dwell(dwell), .I(I),
        .y(y), .sel(sel), .y_valid(y_valid), .y_ready(y_ready), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en; logic [7:0] mask; logic [7:0] dwell; logic rdy;
        logic y; logic [2:0] sel; logic v; logic fs;
    } vec_t;
    vec_t tv[$];

    // Reference: beats, gap cycles left, and a modular search for the next channel
    bit m_valid, m_fs;
    int m_ch, m_gap, act, start, c;
    logic [W-1:0] m_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_fs = 0; m_ch = 0; m_y = '0; m_gap = 0;
        end else begin
            act = 0;
            if (m_valid) begin
                if (y_ready) begin
                    if (!en || mask == 0) begin m_valid = 0; m_fs = 0; end
                    else if (dwell == 0) act = 2;
                    else begin m_valid = 0; m_fs = 0; m_gap = dwell; end
                end
            end else if (m_gap == 0) begin
                if (en && mask != 0) act = 1;
            end else if (!en) m_gap = 0;
            else if (m_gap == 1) begin
                m_gap = 0;
                if (mask != 0) act = 2;
            end else m_gap = m_gap - 1;
            if (act != 0) begin
                start = (act == 1) ? N-1 : m_ch;
                c = -1;
                for (int k = 1; k <= N; k++)
                    if (c < 0 && mask[(start+k)%N]) c = (start+k)%N;
                m_fs = (act == 1) || (c <= m_ch);
                m_ch = c;
                m_y = I[c*W +: W];
                m_valid = 1;
            end
        end
    end

    function automatic vec_t mk(logic e, logic [7:0] m, logic [7:0] d, logic r,
                                logic ey, logic [2:0] es, logic ev, logic ef);
        vec_t t;
        t.en = e; t.mask = m; t.dwell = d; t.rdy = r;
        t.y = ey; t.sel = es; t.v = ev; t.fs = ef;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {y, sel, y_valid, frame_start};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        // Full mask, back-to-back beats
        for (int i = 0; i < 9; i++)
            tv.push_back(mk(1, 8'hFF, 0, 1, i[0], 3'(i), 1, i == 0 || i == 8));
        // Sparse mask 10010010 with a 2-cycle gap
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 1, 1, 1));
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 1, 0, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 1, 0, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 0, 4, 1, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 0, 4, 0, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 0, 4, 0, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 7, 1, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 7, 0, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 7, 0, 0));
        tv.push_back(mk(1, 8'h92, 2, 1, 1, 1, 1, 1));

        I = 8'hAA;
        do_reset();
        chk("reset_state", outs(), 0);
        for (int i = 0; i < tv.size(); i++) begin
            if (i == 9) begin
                en = 0;
                do_reset();
            end
            en = tv[i].en; mask = tv[i].mask; dwell = tv[i].dwell; y_ready = tv[i].rdy;
            tick();
            chk($sformatf("vec%0d", i), outs(), {tv[i].y, tv[i].sel, tv[i].v, tv[i].fs});
        end

        // Backpressure at sel=3 with toggling data
        en = 0; do_reset();
        en = 1; mask = 8'hFF; dwell = 0; y_ready = 1; I = 8'hAA;
        repeat (4) tick();
        chk("bp_sel3", outs(), {1'b1, 3'd3, 1'b1, 1'b0});
        y_ready = 0;
        for (int i = 0; i < 5; i++) begin
            I = ~I;
            tick();
            chk($sformatf("bp_hold%0d", i), outs(), {1'b1, 3'd3, 1'b1, 1'b0});
        end
        y_ready = 1;
        tick();
        chk("bp_next", outs(), {I[4], 3'd4, 1'b1, 1'b0});

        // Enable drop while pending, then during a gap
        en = 0; y_ready = 0;
        tick(); chk("drop_hold0", outs(), {I[4], 3'd4, 1'b1, 1'b0});
        tick(); chk("drop_hold1", outs(), {I[4], 3'd4, 1'b1, 1'b0});
        y_ready = 1;
        tick(); chk("drop_done", outs(), {I[4], 3'd4, 1'b0, 1'b0});
        tick(); chk("drop_idle", outs(), {I[4], 3'd4, 1'b0, 1'b0});
        en = 1; dwell = 5; I = 8'hAA;
        tick(); chk("gap_beat", outs(), {1'b0, 3'd0, 1'b1, 1'b1});
        tick(); chk("gap_enter", {31'd0, y_valid}, 0);
        tick(); chk("gap_in", {31'd0, y_valid}, 0);
        en = 0;
        tick(); chk("gap_en_off", {31'd0, y_valid}, 0);
        en = 1;
        tick(); chk("gap_restart", outs(), {1'b0, 3'd0, 1'b1, 1'b1});

        // Async reset between edges mid-scan
        en = 0; do_reset();
        en = 1; mask = 8'hFF; dwell = 0; y_ready = 1; I = 8'hAA;
        repeat (6) tick();
        chk("pre_areset", outs(), {1'b1, 3'd5, 1'b1, 1'b0});
        #2 rst_n = 0;
        #1 chk("areset_now", outs(), 0);
        rst_n = 1;
        tick();
        chk("areset_restart", outs(), {1'b0, 3'd0, 1'b1, 1'b1});

        // Mask corners
        en = 0; do_reset();
        en = 1; mask = 0; dwell = 0; y_ready = 1; I = 8'hAA;
        repeat (3) begin tick(); chk("mask0_idle", outs(), 0); end
        mask = 8'h20;
        tick(); chk("single0", outs(), {1'b1, 3'd5, 1'b1, 1'b1});
        tick(); chk("single1", outs(), {1'b1, 3'd5, 1'b1, 1'b1});
        y_ready = 0; mask = 8'hFF;
        tick(); chk("mask_chg_hold", outs(), {1'b1, 3'd5, 1'b1, 1'b1});
        mask = 8'h81; y_ready = 1;
        tick(); chk("mask_chg_next", outs(), {1'b1, 3'd7, 1'b1, 1'b0});
        tick(); chk("mask_chg_wrap", outs(), {1'b0, 3'd0, 1'b1, 1'b1});

        // Randomized run against the reference model
        en = 0; do_reset();
        for (int i = 0; i < 1500; i++) begin
            en = $urandom_range(0, 9) != 0;
            case ($urandom_range(0, 7))
                0: mask = '0;
                1: mask = 8'(1 << $urandom_range(0, 7));
                default: mask = 8'($urandom);
            endcase
            dwell = 8'($urandom_range(0, 3));
            y_ready = $urandom_range(0, 3) != 0;
            I = 8'($urandom);
            tick();
            chk("rand", outs(), {m_y, 3'(m_ch), m_valid, m_fs});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
